// File: rtl/updown_mod_counter.sv
// updown_mod_counter: N-bit up/down modulo counter with run-time bound,
// wrap/saturate mode, synchronous load and optional step prescaler.
//
// Ports:
//   i_clk       rising-edge clock
//   i_reset     asynchronous active-high reset, clears all state
//   i_en        count enable
//   i_load      synchronous load strobe (highest priority)
//   i_load_val  value to load, clamped to i_max
//   i_up        direction, 1 = up, 0 = down
//   i_sat       bound mode, 1 = saturate, 0 = wrap
//   i_max       inclusive upper bound
//   i_presc     prescaler divide value (COUNTER_PRESC_EN only)
//   o_count     registered count
//   o_tc        terminal count, combinational from count/up/max
//   o_wrap      one-cycle registered pulse on a wrap event
//
// Build option: define COUNTER_PRESC_EN to add i_presc and a
// PRESC_W-bit prescaler; the counter then steps once per i_presc+1
// enabled cycles.

module updown_mod_counter #(
  parameter int N       = 6,
  parameter int PRESC_W = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_load,
  input  logic [N-1:0]       i_load_val,
  input  logic               i_up,
  input  logic               i_sat,
  input  logic [N-1:0]       i_max,
`ifdef COUNTER_PRESC_EN
  input  logic [PRESC_W-1:0] i_presc,
`endif
  output logic [N-1:0]       o_count,
  output logic               o_tc,
  output logic               o_wrap
);

  logic [N-1:0] r_count;
  logic         r_wrap;
  logic [N-1:0] w_next;
  logic         w_wrap_evt;
  logic [N-1:0] w_load_clamped;
  logic         w_tick;
  logic         w_step;

`ifdef COUNTER_PRESC_EN
  logic [PRESC_W-1:0] r_presc;

  assign w_tick = (r_presc == i_presc);

  // Prescaler only advances on enabled cycles, so en=0 freezes the
  // phase; load restarts it so the first step after a load is a full
  // prescale period away.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_presc <= '0;
    end else if (i_load) begin
      r_presc <= '0;
    end else if (i_en) begin
      if (w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  assign w_step = i_en & w_tick;

  assign w_load_clamped = (i_load_val > i_max) ? i_max : i_load_val;

  // Next value for a step. Bounds are handled explicitly so nothing
  // relies on N-bit arithmetic overflow.
  always_comb begin
    w_next     = r_count;
    w_wrap_evt = 1'b0;
    if (i_up) begin
      if (r_count < i_max) begin
        w_next = r_count + 1'b1;
      end else if (i_sat) begin
        w_next = i_max;
      end else begin
        w_next     = '0;
        w_wrap_evt = 1'b1;
      end
    end else begin
      if (r_count > i_max) begin
        // Bound was lowered below the count: snap down, no wrap.
        w_next = i_max;
      end else if (r_count == '0) begin
        if (i_sat) begin
          w_next = '0;
        end else begin
          w_next     = i_max;
          w_wrap_evt = 1'b1;
        end
      end else begin
        w_next = r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (i_load) begin
      r_count <= w_load_clamped;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
      r_count <= w_next;
      r_wrap  <= w_wrap_evt;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign o_count = r_count;
  assign o_wrap  = r_wrap;
  assign o_tc    = i_up ? (r_count >= i_max) : (r_count == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed plus randomized checks of
// updown_mod_counter against an integer reference model.

module tb_updown_mod_counter;

  localparam int N  = 6;
  localparam int PW = 4;

  logic          clk;
  logic          reset;
  logic          en;
  logic          load;
  logic [N-1:0]  load_val;
  logic          up;
  logic          sat;
  logic [N-1:0]  max;
  logic [N-1:0]  count;
  logic          tc;
  logic          wrap;
`ifdef COUNTER_PRESC_EN
  logic [PW-1:0] presc;
`endif

  int n_cmp;
  int n_bad;

  // reference state
  int m_cnt;
  int m_wrap;
  int m_pre;

  updown_mod_counter #(.N(N), .PRESC_W(PW)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_en       (en),
    .i_load     (load),
    .i_load_val (load_val),
    .i_up       (up),
    .i_sat      (sat),
    .i_max      (max),
`ifdef COUNTER_PRESC_EN
    .i_presc    (presc),
`endif
    .o_count    (count),
    .o_tc       (tc),
    .o_wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected behaviour for one clock edge, from the current inputs.
  task automatic model_edge();
    int mx;
    bit tick;
    mx = int'(max);
    tick = 1'b1;
`ifdef COUNTER_PRESC_EN
    if (!load && en) begin
      tick = (m_pre == int'(presc));
      m_pre = tick ? 0 : (m_pre + 1) % (1 << PW);
    end
`endif
    if (load) begin
      m_cnt  = (int'(load_val) > mx) ? mx : int'(load_val);
      m_wrap = 0;
      m_pre  = 0;
    end else if (en && tick) begin
      m_wrap = 0;
      if (up) begin
        if (m_cnt < mx) m_cnt = m_cnt + 1;
        else if (sat) m_cnt = mx;
        else begin
          m_cnt  = 0;
          m_wrap = 1;
        end
      end else begin
        if (m_cnt > mx) m_cnt = mx;
        else if (m_cnt == 0) begin
          if (!sat) begin
            m_cnt  = mx;
            m_wrap = 1;
          end
        end else m_cnt = m_cnt - 1;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  function automatic int model_tc();
    if (up) return (m_cnt >= int'(max)) ? 1 : 0;
    return (m_cnt == 0) ? 1 : 0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".count"}, int'(count), m_cnt);
    chk({tag, ".wrap"}, int'(wrap), m_wrap);
    chk({tag, ".tc"}, int'(tc), model_tc());
  endtask

  // One clock: predict, take the edge, sample 1 time unit later.
  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  int seen_wrap;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_cnt = 0;
    m_wrap = 0;
    m_pre = 0;
    reset = 1'b1;
    en = 1'b0;
    load = 1'b0;
    load_val = '0;
    up = 1'b1;
    sat = 1'b0;
    max = 6'd20;
`ifdef COUNTER_PRESC_EN
    presc = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // 1: up/wrap over 0..20
    en = 1'b1;
    for (int i = 1; i <= 20; i++) cyc("up_wrap");
    chk("t1.at_max", int'(count), 20);
    chk("t1.tc_at_max", int'(tc), 1);
    cyc("up_wrap");
    chk("t1.back0", int'(count), 0);
    chk("t1.wrap_pulse", int'(wrap), 1);
    cyc("up_wrap");
    chk("t1.wrap_drop", int'(wrap), 0);

    // 2: down/saturate from 3
    up = 1'b0;
    sat = 1'b1;
    load = 1'b1;
    load_val = 6'd3;
    cyc("dn_load");
    load = 1'b0;
    for (int i = 0; i < 5; i++) cyc("dn_sat");
    chk("t2.floor", int'(count), 0);

    // 3: clamped load, load beats en
    load = 1'b1;
    load_val = 6'd50;
    cyc("ld_clamp");
    chk("t3.clamp", int'(count), 20);
    load_val = 6'd7;
    cyc("ld_pri");
    chk("t3.ld_pri", int'(count), 7);
    load = 1'b0;

    // 4: bound lowered below the count
    up = 1'b1;
    sat = 1'b0;
    load = 1'b1;
    load_val = 6'd15;
    cyc("ld15");
    load = 1'b0;
    max = 6'd10;
    cyc("lower_up");
    chk("t4.up_wrap", int'(wrap), 1);
    max = 6'd20;
    load = 1'b1;
    cyc("ld15b");
    load = 1'b0;
    max = 6'd10;
    up = 1'b0;
    cyc("lower_dn");
    chk("t4.dn_snap", int'(count), 10);

    // max = 0 corner in both modes
    max = 6'd0;
    up = 1'b1;
    for (int i = 0; i < 3; i++) cyc("max0_wrap");
    sat = 1'b1;
    for (int i = 0; i < 3; i++) cyc("max0_sat");

    // 5: asynchronous reset mid-count
    max = 6'd20;
    sat = 1'b0;
    load = 1'b1;
    load_val = 6'd12;
    cyc("ld12");
    load = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    m_cnt = 0;
    m_wrap = 0;
    m_pre = 0;
    chk("t5.async_cnt", int'(count), 0);
    chk("t5.async_wrap", int'(wrap), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("post_rst");
    chk("t5.resume", int'(count), 1);

`ifdef COUNTER_PRESC_EN
    // 6: divide by 4, en gap delays step
    presc = 4'd3;
    load = 1'b1;
    load_val = 6'd0;
    cyc("p_ld");
    load = 1'b0;
    for (int i = 0; i < 8; i++) cyc("presc");
    chk("t6.two_steps", int'(count), 2);
    cyc("presc");
    en = 1'b0;
    cyc("p_gap");
    cyc("p_gap");
    en = 1'b1;
    cyc("presc");
    cyc("presc");
    chk("t6.delayed", int'(count), 2);
    cyc("presc");
    chk("t6.stepped", int'(count), 3);
`endif

    // randomized run
    seen_wrap = 0;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 24) == 0);
      load_val = N'($urandom);
      if ($urandom_range(0, 39) == 0) up = ~up;
      if ($urandom_range(0, 49) == 0) sat = ~sat;
      if ($urandom_range(0, 59) == 0) max = N'($urandom_range(0, 63));
`ifdef COUNTER_PRESC_EN
      if ($urandom_range(0, 79) == 0) presc = PW'($urandom_range(0, 3));
`endif
      cyc("rand");
      if (wrap) seen_wrap++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
